// File: rtl/ahb2apb_ctrl.sv
// AHB-Lite to APB bridge controller: turns single AHB transfers into
// APB setup/enable pairs and stalls the AHB master until each completes.
module ahb2apb_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_SPAN = 32'h0400_0000
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic                  Hreadyin,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic                  Hreadyout,
    output logic [1:0]            Hresp,
    input  logic [DATA_WIDTH-1:0] Prdata,
    output logic [3:0]            Pselx,
    output logic                  Penable,
    output logic                  Pwrite,
    output logic [ADDR_WIDTH-1:0] Paddr,
    output logic [DATA_WIDTH-1:0] Pwdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WWAIT,
        S_READ,
        S_WRITE,
        S_RENABLE,
        S_WENABLE
    } state_t;

    state_t                r_state;
    logic [3:0]            r_sel;
    logic [3:0]            r_pselx;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_hreadyout;

    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_inreg;
    logic                  w_valid;
    logic [3:0]            w_dec;

    // Slave index is the span-sized slot the offset falls into
    assign w_off   = Haddr - BASE_ADDR;
    assign w_idx   = w_off / SLAVE_SPAN;
    assign w_inreg = (Haddr >= BASE_ADDR) && (w_idx < ADDR_WIDTH'(4));
    assign w_valid = Hreadyin && Htrans[1] && w_inreg;
    assign w_dec   = 4'b0001 << w_idx[1:0];

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_hreadyout <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE, S_RENABLE, S_WENABLE: begin
                    r_penable <= 1'b0;
                    if (w_valid) begin
                        r_paddr     <= Haddr;
                        r_pwrite    <= Hwrite;
                        r_sel       <= w_dec;
                        r_hreadyout <= 1'b0;
                        if (Hwrite) begin
                            r_state <= S_WWAIT;
                            r_pselx <= '0;
                        end else begin
                            r_state <= S_READ;
                            r_pselx <= w_dec;
                        end
                    end else begin
                        r_state     <= S_IDLE;
                        r_pselx     <= '0;
                        r_hreadyout <= 1'b1;
                    end
                end
                // Write data only arrives in the AHB data phase
                S_WWAIT: begin
                    r_pwdata <= Hwdata;
                    r_pselx  <= r_sel;
                    r_state  <= S_WRITE;
                end
                S_READ: begin
                    r_penable   <= 1'b1;
                    r_hreadyout <= 1'b1;
                    r_state     <= S_RENABLE;
                end
                S_WRITE: begin
                    r_penable   <= 1'b1;
                    r_hreadyout <= 1'b1;
                    r_state     <= S_WENABLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Pselx     = r_pselx;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;
    assign Hreadyout = r_hreadyout;
    assign Hresp     = 2'b00;
    assign Hrdata    = (r_state == S_RENABLE) ? Prdata : '0;

endmodule

// File: tb/tb_ahb2apb_ctrl.sv
// Scoreboard bench for ahb2apb_ctrl: directed AHB transfers push
// per-cycle expected outputs; a negedge monitor pops and compares.
module tb_ahb2apb_ctrl;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Hrdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Prdata;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;

    ahb2apb_ctrl dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Hwrite    (Hwrite),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hrdata    (Hrdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Prdata    (Prdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata)
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        int          cyc;
        string       name;
        logic [3:0]  sel;
        logic        en;
        logic        rdy;
        logic [31:0] rdata;
        bit          ca;
        logic        wr;
        logic [31:0] addr;
        bit          cw;
        logic [31:0] wd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_en = 1'b0;

    always @(posedge Hclk) cyc++;

    task automatic ex(input int c, input string n, input logic [3:0] s,
                      input logic en, input logic rdy, input logic [31:0] rd,
                      input bit ca = 0, input logic wr = 0,
                      input logic [31:0] a = 0, input bit cw = 0,
                      input logic [31:0] wd = 0);
        exp_t e;
        e.cyc = c; e.name = n; e.sel = s; e.en = en; e.rdy = rdy;
        e.rdata = rd; e.ca = ca; e.wr = wr; e.addr = a; e.cw = cw; e.wd = wd;
        q.push_back(e);
    endtask

    task automatic idle_ex(input int c, input string n);
        ex(c, n, 4'b0000, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic addr_phase(input logic [1:0] t, input logic w,
                              input logic [31:0] a);
        Htrans = t;
        Hwrite = w;
        Haddr  = a;
    endtask

    // Monitor: compare every expectation due this cycle
    always @(negedge Hclk) begin
        exp_t e;
        bit   ok;
        if (Penable) begin
            checks++;
            if (prev_en) begin
                errors++;
                $display("FAIL penable_pulse cyc %0d: Penable high two cycles, required single pulse", cyc);
            end
        end
        prev_en = Penable;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            ok = (e.cyc == cyc) && (Pselx === e.sel) && (Penable === e.en)
                 && (Hreadyout === e.rdy) && (Hrdata === e.rdata)
                 && (Hresp === 2'b00)
                 && (!e.ca || (Pwrite === e.wr && Paddr === e.addr))
                 && (!e.cw || Pwdata === e.wd);
            if (!ok) begin
                errors++;
                $display("FAIL %s cyc %0d/%0d: got sel=%b en=%b rdy=%b rdata=%h resp=%b wr=%b addr=%h wd=%h required sel=%b en=%b rdy=%b rdata=%h resp=00 wr=%b addr=%h wd=%h",
                         e.name, cyc, e.cyc, Pselx, Penable, Hreadyout, Hrdata,
                         Hresp, Pwrite, Paddr, Pwdata, e.sel, e.en, e.rdy,
                         e.rdata, e.wr, e.addr, e.wd);
            end
        end
    end

    initial begin
        int n;
        Hresetn  = 1'b0;
        Hreadyin = 1'b1;
        Htrans   = 2'b00;
        Hwrite   = 1'b0;
        Haddr    = 32'h0;
        Hwdata   = 32'h0;
        Prdata   = 32'hCAFE_0001;

        tick();
        ex(cyc, "reset", 4'b0, 1'b0, 1'b1, 32'h0, 1, 1'b0, 32'h0, 1, 32'h0);
        tick();
        Hresetn = 1'b1;
        tick();

        // Single read
        n = cyc;
        addr_phase(2'b10, 1'b0, 32'h8400_0010);
        idle_ex(n, "rd_addr");
        ex(n + 1, "rd_setup", 4'b0010, 1'b0, 1'b0, 32'h0, 1, 1'b0, 32'h8400_0010);
        ex(n + 2, "rd_enable", 4'b0010, 1'b1, 1'b1, 32'hCAFE_0001, 1, 1'b0, 32'h8400_0010);
        tick();
        tick();
        Htrans = 2'b00;
        idle_ex(n + 3, "rd_idle");
        tick();
        tick();

        // Single write
        n = cyc;
        addr_phase(2'b10, 1'b1, 32'h8C00_0004);
        idle_ex(n, "wr_addr");
        ex(n + 1, "wr_wait", 4'b0000, 1'b0, 1'b0, 32'h0);
        tick();
        Hwdata = 32'h1234_5678;
        ex(n + 2, "wr_setup", 4'b1000, 1'b0, 1'b0, 32'h0, 1, 1'b1, 32'h8C00_0004, 1, 32'h1234_5678);
        ex(n + 3, "wr_enable", 4'b1000, 1'b1, 1'b1, 32'h0, 1, 1'b1, 32'h8C00_0004, 1, 32'h1234_5678);
        idle_ex(n + 4, "wr_idle");
        tick();
        Htrans = 2'b00;
        Hwdata = 32'h0;
        tick();
        tick();
        tick();

        // Back-to-back read then write
        n = cyc;
        Prdata = 32'hA5A5_0002;
        addr_phase(2'b10, 1'b0, 32'h8000_0000);
        ex(n + 1, "b2b_rsetup", 4'b0001, 1'b0, 1'b0, 32'h0, 1, 1'b0, 32'h8000_0000);
        ex(n + 2, "b2b_renable", 4'b0001, 1'b1, 1'b1, 32'hA5A5_0002, 1, 1'b0, 32'h8000_0000);
        tick();
        tick();
        addr_phase(2'b10, 1'b1, 32'h8800_0008);
        ex(n + 3, "b2b_wwait", 4'b0000, 1'b0, 1'b0, 32'h0);
        tick();
        Hwdata = 32'hDEAD_BEEF;
        ex(n + 4, "b2b_wsetup", 4'b0100, 1'b0, 1'b0, 32'h0, 1, 1'b1, 32'h8800_0008, 1, 32'hDEAD_BEEF);
        ex(n + 5, "b2b_wenable", 4'b0100, 1'b1, 1'b1, 32'h0, 1, 1'b1, 32'h8800_0008, 1, 32'hDEAD_BEEF);
        idle_ex(n + 6, "b2b_idle");
        tick();
        Htrans = 2'b00;
        tick();
        tick();
        tick();

        // Ignored transfers
        addr_phase(2'b00, 1'b0, 32'h8000_0000);
        idle_ex(cyc + 1, "ign_idle");
        tick();
        addr_phase(2'b01, 1'b0, 32'h8000_0000);
        idle_ex(cyc + 1, "ign_busy");
        tick();
        addr_phase(2'b10, 1'b0, 32'h9000_0000);
        idle_ex(cyc + 1, "ign_outside");
        tick();
        addr_phase(2'b11, 1'b1, 32'h7FFF_FFFC);
        idle_ex(cyc + 1, "ign_below");
        tick();
        Hreadyin = 1'b0;
        addr_phase(2'b10, 1'b0, 32'h8000_0000);
        idle_ex(cyc + 1, "ign_notready");
        tick();
        Hreadyin = 1'b1;
        Htrans = 2'b00;
        tick();

        // Top of region, SEQ transfer
        n = cyc;
        Prdata = 32'h0000_FFFF;
        addr_phase(2'b11, 1'b0, 32'h8FFF_FFFC);
        ex(n + 1, "top_setup", 4'b1000, 1'b0, 1'b0, 32'h0, 1, 1'b0, 32'h8FFF_FFFC);
        ex(n + 2, "top_enable", 4'b1000, 1'b1, 1'b1, 32'h0000_FFFF, 1, 1'b0, 32'h8FFF_FFFC);
        tick();
        tick();
        Htrans = 2'b00;
        tick();
        tick();

        // Reset during write setup
        n = cyc;
        addr_phase(2'b10, 1'b1, 32'h8000_0100);
        tick();
        Hwdata = 32'h5555_AAAA;
        tick();
        Hresetn = 1'b0;
        ex(n + 2, "rst_async", 4'b0, 1'b0, 1'b1, 32'h0, 1, 1'b0, 32'h0, 1, 32'h0);
        ex(n + 3, "rst_hold", 4'b0, 1'b0, 1'b1, 32'h0, 1, 1'b0, 32'h0, 1, 32'h0);
        Htrans = 2'b00;
        tick();
        tick();
        Hresetn = 1'b1;
        tick();

        n = cyc;
        Prdata = 32'h0BAD_F00D;
        addr_phase(2'b10, 1'b0, 32'h8000_0000);
        ex(n + 1, "post_setup", 4'b0001, 1'b0, 1'b0, 32'h0, 1, 1'b0, 32'h8000_0000);
        ex(n + 2, "post_enable", 4'b0001, 1'b1, 1'b1, 32'h0BAD_F00D, 1, 1'b0, 32'h8000_0000);
        tick();
        tick();
        Htrans = 2'b00;
        idle_ex(n + 3, "post_idle");
        tick();
        tick();
        tick();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
